// File: rtl/blitter_pkg.sv
// Shared types, default geometry and address helper for the sprite compositor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BG,
    ST_SPR_SEL,
    ST_SPR_DRAW,
    ST_SPR_FLUSH,
    ST_DONE
  } blit_state_t;

  localparam int DEF_SCREEN_W   = 320;
  localparam int DEF_SCREEN_H   = 240;
  localparam int DEF_X_W        = 9;
  localparam int DEF_Y_W        = 8;
  localparam int DEF_SPR_W      = 16;
  localparam int DEF_SPR_H      = 16;
  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_COLOUR_W   = 12;
  localparam int DEF_ADDR_W     = 17;

  localparam logic [11:0] DEF_BG_COLOUR  = 12'h884;
  localparam logic [11:0] DEF_TRANSP_KEY = 12'hF0F;

  // Sprite bank is NUM_SPRITES images of spr_w*spr_h words laid out back to
  // back; within an image the words are row-major.
  function automatic int unsigned blit_addr(
    input int unsigned slot,
    input int unsigned sy,
    input int unsigned sx,
    input int unsigned spr_w,
    input int unsigned spr_h
  );
    return slot * spr_w * spr_h + sy * spr_w + sx;
  endfunction

endpackage

// File: rtl/blit_pixel_pipe.sv
// Aligns sprite pixel coordinates with the ROM word and masks clipped/keyed pixels.
// Latency: 1 cycle from address issue to pix_* (matches the registered ROM).
// Backpressure: none; every issued address produces one pix_vld cycle.
//
// Ports: in_vld/org_*/off_* describe the pixel whose ROM address is issued this
// cycle; rom_data is the word for the pixel issued last cycle; pix_* describe
// that same pixel, with pix_plot cleared when it is off-screen or transparent.
module blit_pixel_pipe
  import blitter_pkg::*;
#(
  parameter int              X_W        = DEF_X_W,
  parameter int              Y_W        = DEF_Y_W,
  parameter int              SX_W       = 4,
  parameter int              SY_W       = 4,
  parameter int              COLOUR_W   = DEF_COLOUR_W,
  parameter int              SCREEN_W   = DEF_SCREEN_W,
  parameter int              SCREEN_H   = DEF_SCREEN_H,
  parameter bit              TRANSP_EN  = 1'b1,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = DEF_TRANSP_KEY
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                in_vld,
  input  logic [X_W-1:0]      org_x,
  input  logic [Y_W-1:0]      org_y,
  input  logic [SX_W-1:0]     off_x,
  input  logic [SY_W-1:0]     off_y,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic                pix_vld,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic                pix_plot
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

  // One extra bit so a sprite hanging off the right/bottom edge is seen as
  // out of range instead of wrapping back onto the screen.
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic [X_W:0] d_x;
  logic [Y_W:0] d_y;
  logic         d_vld;
  logic         clip;
  logic         keyed;

  assign sum_x = {1'b0, org_x} + (X_W+1)'(off_x);
  assign sum_y = {1'b0, org_y} + (Y_W+1)'(off_y);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      d_vld <= 1'b0;
      d_x   <= '0;
      d_y   <= '0;
    end else begin
      d_vld <= in_vld;
      if (in_vld) begin
        d_x <= sum_x;
        d_y <= sum_y;
      end
    end
  end

  always_comb begin
    clip     = (d_x >= X_LIM) || (d_y >= Y_LIM);
    keyed    = TRANSP_EN && (rom_data == TRANSP_KEY);
    pix_vld  = d_vld;
    pix_x    = d_x[X_W-1:0];
    pix_y    = d_y[Y_W-1:0];
    pix_plot = d_vld && !clip && !keyed;
  end

endmodule

// File: rtl/sprite_blitter.sv
// Frame compositor: background fill, then up to NUM_SPRITES sprites copied from ROM.
// Latency: first background plot 1 cycle after start; sprite pixel 2 cycles after its address.
// Backpressure: none on the pixel port; start is ignored (not queued) while busy.
//
// Ports: start/spr_en/spr_x/spr_y from game state (sampled on start only);
// rom_addr/rom_data to the synchronous sprite ROM; x/y/colour/plot to the
// VGA adapter write port; busy spans the frame, done pulses on completion.
module sprite_blitter
  import blitter_pkg::*;
#(
  parameter int              SCREEN_W    = DEF_SCREEN_W,
  parameter int              SCREEN_H    = DEF_SCREEN_H,
  parameter int              X_W         = DEF_X_W,
  parameter int              Y_W         = DEF_Y_W,
  parameter int              SPR_W       = DEF_SPR_W,
  parameter int              SPR_H       = DEF_SPR_H,
  parameter int              NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int              COLOUR_W    = DEF_COLOUR_W,
  parameter int              ADDR_W      = DEF_ADDR_W,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = DEF_BG_COLOUR,
  parameter bit              TRANSP_EN   = 1'b1,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = DEF_TRANSP_KEY
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [NUM_SPRITES-1:0]     spr_en,
  input  logic [NUM_SPRITES*X_W-1:0] spr_x,
  input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [COLOUR_W-1:0]        rom_data,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [COLOUR_W-1:0]        colour,
  output logic                       plot,
  output logic                       busy,
  output logic                       done
);

  localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int SX_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int SY_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPRITES - 1);
  localparam logic [SX_W-1:0]   LAST_SX   = SX_W'(SPR_W - 1);
  localparam logic [SY_W-1:0]   LAST_SY   = SY_W'(SPR_H - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(SCREEN_H - 1);

  blit_state_t state_q, state_d;

  // Frame parameters are frozen at start so the game logic may move sprites
  // while a frame is being drawn.
  logic [NUM_SPRITES-1:0]     sh_en;
  logic [NUM_SPRITES*X_W-1:0] sh_x;
  logic [NUM_SPRITES*Y_W-1:0] sh_y;

  logic [SLOT_W-1:0] slot_q;
  logic [SX_W-1:0]   sx_q;
  logic [SY_W-1:0]   sy_q;

  logic [X_W-1:0] cur_ox;
  logic [Y_W-1:0] cur_oy;

  logic bg_last;
  logic slot_last;
  logic spr_last;
  logic spr_issue;

  logic           pix_vld;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           pix_plot;

  // The x/y output registers double as the background raster counter.
  assign bg_last   = (x == LAST_X) && (y == LAST_Y);
  assign slot_last = (slot_q == LAST_SLOT);
  assign spr_last  = (sx_q == LAST_SX) && (sy_q == LAST_SY);

  assign cur_ox = sh_x[slot_q*X_W +: X_W];
  assign cur_oy = sh_y[slot_q*Y_W +: Y_W];

  assign rom_addr = ADDR_W'(blit_addr(32'(slot_q), 32'(sy_q), 32'(sx_q), SPR_W, SPR_H));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_BG;
      ST_BG:        if (bg_last) state_d = ST_SPR_SEL;
      ST_SPR_SEL: begin
        if (sh_en[slot_q]) state_d = ST_SPR_DRAW;
        else if (slot_last) state_d = ST_DONE;
      end
      ST_SPR_DRAW:  if (spr_last) state_d = ST_SPR_FLUSH;
      ST_SPR_FLUSH: state_d = slot_last ? ST_DONE : ST_SPR_SEL;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    spr_issue = (state_q == ST_SPR_DRAW);
  end

  // ---------------- shadow registers and sprite counters ----------------
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sh_en  <= '0;
      sh_x   <= '0;
      sh_y   <= '0;
      slot_q <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_en  <= spr_en;
            sh_x   <= spr_x;
            sh_y   <= spr_y;
            slot_q <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
          end
        end
        ST_SPR_SEL: begin
          if (sh_en[slot_q]) begin
            sx_q <= '0;
            sy_q <= '0;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        ST_SPR_DRAW: begin
          if (sx_q == LAST_SX) begin
            sx_q <= '0;
            sy_q <= sy_q + 1'b1;
          end else begin
            sx_q <= sx_q + 1'b1;
          end
        end
        ST_SPR_FLUSH: slot_q <= slot_q + 1'b1;
        default: ;
      endcase
    end
  end

  blit_pixel_pipe #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .SX_W       (SX_W),
    .SY_W       (SY_W),
    .COLOUR_W   (COLOUR_W),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .TRANSP_EN  (TRANSP_EN),
    .TRANSP_KEY (TRANSP_KEY)
  ) u_pipe (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .in_vld   (spr_issue),
    .org_x    (cur_ox),
    .org_y    (cur_oy),
    .off_x    (sx_q),
    .off_y    (sy_q),
    .rom_data (rom_data),
    .pix_vld  (pix_vld),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_plot (pix_plot)
  );

  // ---------------- pixel write port ----------------
  // Background pixels are generated one cycle ahead (the start edge already
  // presents (0,0)) so the fill occupies exactly the BG state cycles.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      x      <= '0;
      y      <= '0;
      colour <= BG_COLOUR;
      plot   <= 1'b1;
    end else if (state_q == ST_BG && !bg_last) begin
      colour <= BG_COLOUR;
      plot   <= 1'b1;
      if (x == LAST_X) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else if (pix_vld) begin
      x      <= pix_x;
      y      <= pix_y;
      colour <= rom_data;
      plot   <= pix_plot;
    end else begin
      plot <= 1'b0;
    end
  end

endmodule
